// File: rtl/wb_bank_arbiter.sv
// wb_bank_arbiter: two Wishbone-style ports onto two single-port RAM banks, with per-bank alternating priority on conflict
module wb_bank_arbiter #(
  parameter int A_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pA_wb_stb_i,
  input  logic [A_WIDTH:0]   pA_wb_addr_i,
  input  logic [3:0]         pA_wb_we_i,
  input  logic [31:0]        pA_wb_data_i,
  output logic               pA_wb_ack_o,
  output logic               pA_wb_stall_o,
  output logic [31:0]        pA_wb_data_o,
  input  logic               pB_wb_stb_i,
  input  logic [A_WIDTH:0]   pB_wb_addr_i,
  input  logic [3:0]         pB_wb_we_i,
  input  logic [31:0]        pB_wb_data_i,
  output logic               pB_wb_ack_o,
  output logic               pB_wb_stall_o,
  output logic [31:0]        pB_wb_data_o,
  output logic               ram0_en_o,
  output logic [3:0]         ram0_we_o,
  output logic [A_WIDTH-1:0] ram0_addr_o,
  output logic [31:0]        ram0_wdata_o,
  input  logic [31:0]        ram0_rdata_i,
  output logic               ram1_en_o,
  output logic [3:0]         ram1_we_o,
  output logic [A_WIDTH-1:0] ram1_addr_o,
  output logic [31:0]        ram1_wdata_o,
  input  logic [31:0]        ram1_rdata_i,
  output logic [15:0]        conflict_cnt_o
);
  typedef enum logic {PRIO_A = 1'b0, PRIO_B = 1'b1} prio_e;
  prio_e prio0_q, prio0_d, prio1_q, prio1_d;
  logic tgt_a, tgt_b, req_a0, req_a1, req_b0, req_b1, conf0, conf1;
  logic gnt_a0, gnt_a1, gnt_b0, gnt_b1, gnt_a, gnt_b;
  logic ack_a_q, ack_a_d, ack_b_q, ack_b_d;
  logic bank_a_q, bank_a_d, bank_b_q, bank_b_d;
  logic [31:0] hold_a_q, hold_a_d, hold_b_q, hold_b_d, rd_a, rd_b;
  logic [15:0] cnt_q, cnt_d;
  always_comb begin
    tgt_a  = pA_wb_addr_i[A_WIDTH];
    tgt_b  = pB_wb_addr_i[A_WIDTH];
    req_a0 = pA_wb_stb_i & ~tgt_a;
    req_a1 = pA_wb_stb_i & tgt_a;
    req_b0 = pB_wb_stb_i & ~tgt_b;
    req_b1 = pB_wb_stb_i & tgt_b;
    conf0  = req_a0 & req_b0;
    conf1  = req_a1 & req_b1;
    gnt_a0 = req_a0 & (~req_b0 | (prio0_q == PRIO_A));
    gnt_b0 = req_b0 & (~req_a0 | (prio0_q == PRIO_B));
    gnt_a1 = req_a1 & (~req_b1 | (prio1_q == PRIO_A));
    gnt_b1 = req_b1 & (~req_a1 | (prio1_q == PRIO_B));
    gnt_a  = gnt_a0 | gnt_a1;
    gnt_b  = gnt_b0 | gnt_b1;
    pA_wb_stall_o = pA_wb_stb_i & ~gnt_a;
    pB_wb_stall_o = pB_wb_stb_i & ~gnt_b;
  end
  // the loser of a conflict owns the bank on the next conflict
  always_comb begin
    prio0_d = conf0 ? (gnt_a0 ? PRIO_B : PRIO_A) : prio0_q;
    prio1_d = conf1 ? (gnt_a1 ? PRIO_B : PRIO_A) : prio1_q;
  end
  always_comb begin
    ram0_en_o    = gnt_a0 | gnt_b0;
    ram0_we_o    = gnt_a0 ? pA_wb_we_i : gnt_b0 ? pB_wb_we_i : '0;
    ram0_addr_o  = gnt_a0 ? pA_wb_addr_i[A_WIDTH-1:0] : gnt_b0 ? pB_wb_addr_i[A_WIDTH-1:0] : '0;
    ram0_wdata_o = gnt_a0 ? pA_wb_data_i : gnt_b0 ? pB_wb_data_i : '0;
    ram1_en_o    = gnt_a1 | gnt_b1;
    ram1_we_o    = gnt_a1 ? pA_wb_we_i : gnt_b1 ? pB_wb_we_i : '0;
    ram1_addr_o  = gnt_a1 ? pA_wb_addr_i[A_WIDTH-1:0] : gnt_b1 ? pB_wb_addr_i[A_WIDTH-1:0] : '0;
    ram1_wdata_o = gnt_a1 ? pA_wb_data_i : gnt_b1 ? pB_wb_data_i : '0;
  end
  always_comb begin
    ack_a_d      = gnt_a;
    ack_b_d      = gnt_b;
    bank_a_d     = gnt_a ? tgt_a : bank_a_q;
    bank_b_d     = gnt_b ? tgt_b : bank_b_q;
    rd_a         = bank_a_q ? ram1_rdata_i : ram0_rdata_i;
    rd_b         = bank_b_q ? ram1_rdata_i : ram0_rdata_i;
    pA_wb_data_o = ack_a_q ? rd_a : hold_a_q;
    pB_wb_data_o = ack_b_q ? rd_b : hold_b_q;
    hold_a_d     = pA_wb_data_o;
    hold_b_d     = pB_wb_data_o;
    pA_wb_ack_o  = ack_a_q;
    pB_wb_ack_o  = ack_b_q;
    cnt_d        = ((conf0 | conf1) && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
    conflict_cnt_o = cnt_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prio0_q  <= PRIO_A;
      prio1_q  <= PRIO_A;
      ack_a_q  <= 1'b0;
      ack_b_q  <= 1'b0;
      bank_a_q <= 1'b0;
      bank_b_q <= 1'b0;
      hold_a_q <= '0;
      hold_b_q <= '0;
      cnt_q    <= '0;
    end else begin
      prio0_q  <= prio0_d;
      prio1_q  <= prio1_d;
      ack_a_q  <= ack_a_d;
      ack_b_q  <= ack_b_d;
      bank_a_q <= bank_a_d;
      bank_b_q <= bank_b_d;
      hold_a_q <= hold_a_d;
      hold_b_q <= hold_b_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// File: tb/tb_wb_bank_arbiter.sv
// tb_wb_bank_arbiter: directed stimulus with a queue-based ack/data scoreboard and behavioural RAM banks
module tb_wb_bank_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic pA_stb, pB_stb, pA_ack, pB_ack, pA_stall, pB_stall;
  logic [8:0] pA_addr, pB_addr;
  logic [3:0] pA_we, pB_we;
  logic [31:0] pA_wdat, pB_wdat, pA_rdat, pB_rdat;
  logic ram0_en, ram1_en;
  logic [3:0] ram0_we, ram1_we;
  logic [7:0] ram0_addr, ram1_addr;
  logic [31:0] ram0_wdata, ram1_wdata, ram0_rdata, ram1_rdata;
  logic [15:0] cnt;
  logic [31:0] mem0 [256];
  logic [31:0] mem1 [256];
  int checks = 0;
  int errors = 0;
  int cyc_n = 0;
  typedef struct {int due; bit chk; logic [31:0] data;} exp_t;
  exp_t qa[$];
  exp_t qb[$];

  wb_bank_arbiter #(.A_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .pA_wb_stb_i(pA_stb), .pA_wb_addr_i(pA_addr), .pA_wb_we_i(pA_we), .pA_wb_data_i(pA_wdat),
    .pA_wb_ack_o(pA_ack), .pA_wb_stall_o(pA_stall), .pA_wb_data_o(pA_rdat),
    .pB_wb_stb_i(pB_stb), .pB_wb_addr_i(pB_addr), .pB_wb_we_i(pB_we), .pB_wb_data_i(pB_wdat),
    .pB_wb_ack_o(pB_ack), .pB_wb_stall_o(pB_stall), .pB_wb_data_o(pB_rdat),
    .ram0_en_o(ram0_en), .ram0_we_o(ram0_we), .ram0_addr_o(ram0_addr), .ram0_wdata_o(ram0_wdata), .ram0_rdata_i(ram0_rdata),
    .ram1_en_o(ram1_en), .ram1_we_o(ram1_we), .ram1_addr_o(ram1_addr), .ram1_wdata_o(ram1_wdata), .ram1_rdata_i(ram1_rdata),
    .conflict_cnt_o(cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  always @(posedge clk) begin
    if (ram0_en) begin
      ram0_rdata <= mem0[ram0_addr];
      for (int b = 0; b < 4; b++) if (ram0_we[b]) mem0[ram0_addr][8*b +: 8] <= ram0_wdata[8*b +: 8];
    end
    if (ram1_en) begin
      ram1_rdata <= mem1[ram1_addr];
      for (int b = 0; b < 4; b++) if (ram1_we[b]) mem1[ram1_addr][8*b +: 8] <= ram1_wdata[8*b +: 8];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc_n);
    end
  endtask

  always @(negedge clk) begin
    if (qa.size() != 0 && qa[0].due == cyc_n) begin
      chk("ack_a", {31'd0, pA_ack}, 32'd1);
      if (pA_ack && qa[0].chk) chk("data_a", pA_rdat, qa[0].data);
      void'(qa.pop_front());
    end else chk("no_ack_a", {31'd0, pA_ack}, 32'd0);
    if (qb.size() != 0 && qb[0].due == cyc_n) begin
      chk("ack_b", {31'd0, pB_ack}, 32'd1);
      if (pB_ack && qb[0].chk) chk("data_b", pB_rdat, qb[0].data);
      void'(qb.pop_front());
    end else chk("no_ack_b", {31'd0, pB_ack}, 32'd0);
  end

  task automatic drv_a(input logic s, input logic [8:0] a, input logic [3:0] w, input logic [31:0] d);
    pA_stb = s; pA_addr = a; pA_we = w; pA_wdat = d;
  endtask

  task automatic drv_b(input logic s, input logic [8:0] a, input logic [3:0] w, input logic [31:0] d);
    pB_stb = s; pB_addr = a; pB_we = w; pB_wdat = d;
  endtask

  task automatic idle();
    drv_a(0, 9'h0, 4'h0, 32'h0);
    drv_b(0, 9'h0, 4'h0, 32'h0);
  endtask

  task automatic step(input logic xsa, input logic xsb, input bit ca, input logic [31:0] da,
                      input bit cb, input logic [31:0] db);
    @(negedge clk);
    chk("stall_a", {31'd0, pA_stall}, {31'd0, xsa});
    chk("stall_b", {31'd0, pB_stall}, {31'd0, xsb});
    if (rst && pA_stb && !xsa) qa.push_back('{cyc_n + 1, ca, da});
    if (rst && pB_stb && !xsb) qb.push_back('{cyc_n + 1, cb, db});
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem0[i] = 32'h1000_0000 + i;
      mem1[i] = 32'h2000_0000 + i;
    end
    mem1[3] = 32'hDEADBEEF;
    rst = 1'b0;
    drv_a(1, 9'h004, 4'h0, 32'h0);
    drv_b(1, 9'h007, 4'h0, 32'h0);
    #2;
    chk("rst_ram0_en", {31'd0, ram0_en}, 32'd1);
    chk("rst_ram0_addr", {24'd0, ram0_addr}, 32'h4);
    chk("rst_cnt", {16'd0, cnt}, 32'd0);
    chk("rst_data_a", pA_rdat, 32'd0);
    step(0, 1, 0, 0, 0, 0);
    idle();
    step(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    // different banks, simultaneous writes
    drv_a(1, 9'h000, 4'hF, 32'hDEADDEAD);
    drv_b(1, 9'h100, 4'hF, 32'hFEEDBEEF);
    #1;
    chk("wr_ram0_en", {31'd0, ram0_en}, 32'd1);
    chk("wr_ram1_en", {31'd0, ram1_en}, 32'd1);
    chk("wr_ram0_wdata", ram0_wdata, 32'hDEADDEAD);
    chk("wr_ram1_wdata", ram1_wdata, 32'hFEEDBEEF);
    chk("wr_ram1_addr", {24'd0, ram1_addr}, 32'h0);
    step(0, 0, 0, 0, 0, 0);
    drv_a(1, 9'h005, 4'h3, 32'h1111_2222);
    drv_b(0, 9'h0, 4'h0, 32'h0);
    step(0, 0, 0, 0, 0, 0);
    drv_a(1, 9'h000, 4'h0, 32'h0);
    drv_b(1, 9'h100, 4'h0, 32'h0);
    step(0, 0, 1, 32'hDEADDEAD, 1, 32'hFEEDBEEF);
    drv_a(1, 9'h005, 4'h0, 32'h0);
    drv_b(0, 9'h0, 4'h0, 32'h0);
    step(0, 0, 1, 32'h1000_2222, 0, 0);
    idle();
    step(0, 0, 0, 0, 0, 0);
    chk("cnt_no_conflict", {16'd0, cnt}, 32'd0);
    // same-bank conflict on bank 1
    drv_a(1, 9'h103, 4'h0, 32'h0);
    drv_b(1, 9'h103, 4'h0, 32'h0);
    step(0, 1, 1, 32'hDEADBEEF, 0, 0);
    step(1, 0, 0, 0, 1, 32'hDEADBEEF);
    idle();
    step(0, 0, 0, 0, 0, 0);
    chk("cnt_two", {16'd0, cnt}, 32'd2);
    // pipelined single-port reads, then hold
    drv_a(1, 9'h101, 4'h0, 32'h0);
    step(0, 0, 1, 32'h2000_0001, 0, 0);
    drv_a(1, 9'h103, 4'h0, 32'h0);
    step(0, 0, 1, 32'hDEADBEEF, 0, 0);
    idle();
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("hold_a", pA_rdat, 32'hDEADBEEF);
    chk("hold_b", pB_rdat, 32'hDEADBEEF);
    // sustained conflict on bank 0 alternates grants
    drv_a(1, 9'h010, 4'h0, 32'h0);
    drv_b(1, 9'h020, 4'h0, 32'h0);
    for (int i = 0; i < 8; i++)
      if (i % 2 == 0) step(0, 1, 1, 32'h1000_0010, 0, 0);
      else step(1, 0, 0, 0, 1, 32'h1000_0020);
    chk("cnt_ten", {16'd0, cnt}, 32'd10);
    // reset during a pending ack
    step(0, 1, 1, 32'h1000_0010, 0, 0);
    drv_a(1, 9'h011, 4'h0, 32'h0);
    drv_b(0, 9'h0, 4'h0, 32'h0);
    @(negedge clk);
    chk("pre_rst_stall_a", {31'd0, pA_stall}, 32'd0);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    idle();
    chk("mid_rst_data_a", pA_rdat, 32'd0);
    chk("mid_rst_cnt", {16'd0, cnt}, 32'd0);
    step(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    drv_a(1, 9'h012, 4'h0, 32'h0);
    drv_b(1, 9'h022, 4'h0, 32'h0);
    step(0, 1, 1, 32'h1000_0012, 0, 0);
    step(1, 0, 0, 0, 1, 32'h1000_0022);
    idle();
    step(0, 0, 0, 0, 0, 0);
    chk("cnt_after_rst", {16'd0, cnt}, 32'd2);
    // saturation
    rst = 1'b0;
    #2;
    rst = 1'b1;
    drv_a(1, 9'h1AA, 4'h0, 32'h0);
    drv_b(1, 9'h1BB, 4'h0, 32'h0);
    for (int i = 0; i < 65540; i++) begin
      if (i % 2 == 0) step(0, 1, 1, 32'h2000_00AA, 0, 0);
      else step(1, 0, 0, 0, 1, 32'h2000_00BB);
      if (i == 65533) chk("cnt_fffe", {16'd0, cnt}, 32'h0000_FFFE);
      if (i == 65534) chk("cnt_ffff", {16'd0, cnt}, 32'h0000_FFFF);
    end
    chk("cnt_sat", {16'd0, cnt}, 32'h0000_FFFF);
    idle();
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("qa_drained", qa.size(), 32'd0);
    chk("qb_drained", qb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
